// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: nibble width and the
// active-high segment patterns, bit order {g,f,e,d,c,b,a}.
package seg_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [6:0] SEG_0 = 7'b0111111;
    localparam logic [6:0] SEG_1 = 7'b0000110;
    localparam logic [6:0] SEG_2 = 7'b1011011;
    localparam logic [6:0] SEG_3 = 7'b1001111;
    localparam logic [6:0] SEG_4 = 7'b1100110;
    localparam logic [6:0] SEG_5 = 7'b1101101;
    localparam logic [6:0] SEG_6 = 7'b1111101;
    localparam logic [6:0] SEG_7 = 7'b0000111;
    localparam logic [6:0] SEG_8 = 7'b1111111;
    localparam logic [6:0] SEG_9 = 7'b1101111;
    localparam logic [6:0] SEG_A = 7'b1110111;
    localparam logic [6:0] SEG_B = 7'b1111100;
    localparam logic [6:0] SEG_C = 7'b0111001;
    localparam logic [6:0] SEG_D = 7'b1011110;
    localparam logic [6:0] SEG_E = 7'b1111001;
    localparam logic [6:0] SEG_F = 7'b1110001;

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex-nibble to seven-segment decoder, active-high outputs.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [DIGIT_W-1:0] nibble,
    output logic [6:0]         segs
);

    // Map each nibble value to its segment pattern.
    always_comb begin
        // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
        segs = '0;
        case (nibble)
            4'h0: segs = SEG_0;
            4'h1: segs = SEG_1;
            4'h2: segs = SEG_2;
            4'h3: segs = SEG_3;
            4'h4: segs = SEG_4;
            4'h5: segs = SEG_5;
            4'h6: segs = SEG_6;
            4'h7: segs = SEG_7;
            4'h8: segs = SEG_8;
            4'h9: segs = SEG_9;
            4'hA: segs = SEG_A;
            4'hB: segs = SEG_B;
            4'hC: segs = SEG_C;
            4'hD: segs = SEG_D;
            4'hE: segs = SEG_E;
            4'hF: segs = SEG_F;
            default: segs = '0;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scan driver. A prescaler paces digit slots; the
// digit index names the digit driven at the next tick. New data is staged on
// load and moved to the display shadow only at the frame wrap, so a frame is
// never drawn from mixed data.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int CLK_DIV        = 50000,
    parameter int ACTIVE_LOW_OUT = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] value,
    input  logic                          load,
    input  logic [NUM_DIGITS-1:0]         dp_in,
    input  logic [NUM_DIGITS-1:0]         blank_in,
    input  logic                          lz_en,
    output logic [6:0]                    seg,
    output logic                          dp,
    output logic [NUM_DIGITS-1:0]         an,
    output logic                          frame_done
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int VW = DIGIT_W * NUM_DIGITS;
    localparam logic INV = (ACTIVE_LOW_OUT != 0);

    logic [PW-1:0]         presc;
    logic [IW-1:0]         idx;
    logic                  tick;
    logic                  wrap;

    logic [VW-1:0]         stg_value;
    logic [NUM_DIGITS-1:0] stg_dp;
    logic [NUM_DIGITS-1:0] stg_blank;
    logic [VW-1:0]         sh_value;
    logic [NUM_DIGITS-1:0] sh_dp;
    logic [NUM_DIGITS-1:0] sh_blank;

    logic [DIGIT_W-1:0]    cur_nib;
    logic                  cur_dp;
    logic                  cur_blank;
    logic                  lead_zero;
    logic                  all_zero;
    logic [NUM_DIGITS-1:0] an_hot;
    logic [6:0]            dec_seg;
    logic                  suppress;

    logic [6:0]            seg_q;
    logic                  dp_q;
    logic [NUM_DIGITS-1:0] an_q;

    assign tick = (presc == PW'(CLK_DIV - 1));
    assign wrap = tick && (idx == IW'(NUM_DIGITS - 1));

    // Prescaler: count 0..CLK_DIV-1 and wrap; tick marks the last count.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n)    presc <= '0;
        else if (tick) presc <= '0;
        else           presc <= presc + 1'b1;
    end

    // Digit index: advance on each tick, wrapping the last digit back to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        idx <= '0;
        else if (wrap)     idx <= '0;
        else if (tick)     idx <= idx + 1'b1;
    end

    // Staging register: latest load wins until the next frame wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: staging and shadow are reset because a reset must discard pending data and show zeros.
        if (!rst_n) begin
            stg_value <= '0;
            stg_dp    <= '0;
            stg_blank <= '0;
        end else if (load) begin
            stg_value <= value;
            stg_dp    <= dp_in;
            stg_blank <= blank_in;
        end
    end

    // Display shadow: refreshed only at the wrap; a coincident load bypasses staging.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_value <= '0;
            sh_dp    <= '0;
            sh_blank <= '0;
        end else if (wrap) begin
            if (load) begin
                sh_value <= value;
                sh_dp    <= dp_in;
                sh_blank <= blank_in;
            end else begin
                sh_value <= stg_value;
                sh_dp    <= stg_dp;
                sh_blank <= stg_blank;
            end
        end
    end

    // One-cycle pulse following the wrap tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) frame_done <= 1'b0;
        else        frame_done <= wrap;
    end

    // Select the indexed digit and flag it as a leading zero when it and all higher digits are 0.
    always_comb begin
        cur_nib   = '0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        lead_zero = 1'b0;
        all_zero  = 1'b1;
        an_hot    = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            all_zero = all_zero && (sh_value[i*DIGIT_W +: DIGIT_W] == '0);
            if (idx == IW'(i)) begin
                cur_nib   = sh_value[i*DIGIT_W +: DIGIT_W];
                cur_dp    = sh_dp[i];
                cur_blank = sh_blank[i];
                lead_zero = all_zero && (i != 0);
                an_hot[i] = 1'b1;
            end
        end
    end

    seg_hex_decode u_decode (
        .nibble (cur_nib),
        .segs   (dec_seg)
    );

    assign suppress = cur_blank || (lz_en && lead_zero);

    // Output registers: load the selected digit on tick edges only; idle (all off) out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= '0;
            dp_q  <= 1'b0;
            an_q  <= '0;
        end else if (tick) begin
            seg_q <= suppress ? 7'b0 : dec_seg;
            dp_q  <= cur_dp && !cur_blank;
            an_q  <= an_hot;
        end
    end

    assign seg = seg_q ^ {7{INV}};
    assign dp  = dp_q ^ INV;
    assign an  = an_q ^ {NUM_DIGITS{INV}};

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with NUM_DIGITS=4, CLK_DIV=4, active-high pins.
// Timeline: cyc counts rising edges since reset release; ticks fall on cyc = 4,8,12,...
// and the tick at cyc = 4k shows digit (k-1)%4. Wrap ticks are at cyc = 16,32,...
module tb_seg_scan_driver;

    logic        clk;
    logic        rst_n;
    logic [15:0] value;
    logic        load;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic        lz_en;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    int errors;
    int checks;
    int cyc;

    seg_scan_driver #(
        .NUM_DIGITS     (4),
        .CLK_DIV        (4),
        .ACTIVE_LOW_OUT (0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value      (value),
        .load       (load),
        .dp_in      (dp_in),
        .blank_in   (blank_in),
        .lz_en      (lz_en),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        load     = 1'b0;
        value    = '0;
        dp_in    = '0;
        blank_in = '0;
        lz_en    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic test_reset();
        do_reset();
        rst_n = 1'b0;
        #2;
        checks++;
        if (an !== 4'b0000 || seg !== 7'b0 || dp !== 1'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: an=%b seg=%b dp=%b fd=%b, want 0000 0000000 0 0", an, seg, dp, frame_done);
        end
        do_reset();
        run_to(3);
        checks++;
        if (an !== 4'b0000 || seg !== 7'b0) begin
            errors++;
            $display("FAIL pre_first_tick: an=%b seg=%b, want 0000 0000000", an, seg);
        end
        step();
        checks++;
        if (an !== 4'b0001 || seg !== 7'b0111111) begin
            errors++;
            $display("FAIL first_tick: an=%b seg=%b, want 0001 0111111", an, seg);
        end
    endtask

    task automatic test_scan();
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        logic       exp_fd;
        int         pulses;
        pulses = 0;
        do_reset();
        for (int c = 1; c <= 19; c++) begin
            step();
            exp_an  = (c < 4) ? 4'b0000 : (c < 8) ? 4'b0001 : (c < 12) ? 4'b0010 :
                      (c < 16) ? 4'b0100 : 4'b1000;
            exp_seg = (c < 4) ? 7'b0 : 7'b0111111;
            exp_fd  = (c == 16);
            if (frame_done === 1'b1) pulses++;
            checks++;
            if (an !== exp_an) begin
                errors++;
                $display("FAIL scan_an c=%0d: got %b want %b", c, an, exp_an);
            end
            checks++;
            if (seg !== exp_seg) begin
                errors++;
                $display("FAIL scan_seg c=%0d: got %b want %b", c, seg, exp_seg);
            end
            checks++;
            if (frame_done !== exp_fd) begin
                errors++;
                $display("FAIL scan_frame_done c=%0d: got %b want %b", c, frame_done, exp_fd);
            end
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL scan_pulse_count: got %0d want 1", pulses);
        end
    endtask

    task automatic test_load_midframe();
        logic [6:0] exp_seg [8];
        logic [3:0] exp_an;
        exp_seg = '{7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111,
                    7'b1110001, 7'b1001111, 7'b1110111, 7'b0000110};
        do_reset();
        run_to(6);
        load  = 1'b1;
        value = 16'h1A3F;
        step();
        load  = 1'b0;
        value = 16'h0000;
        for (int k = 1; k < 8; k++) begin
            run_to(4 * (k + 1));
            exp_an = 4'b0001 << (k % 4);
            checks++;
            if (an !== exp_an || seg !== exp_seg[k]) begin
                errors++;
                $display("FAIL load_midframe tick%0d: an=%b seg=%b want %b %b", k, an, seg, exp_an, exp_seg[k]);
            end
        end
    endtask

    task automatic test_lz();
        logic [6:0] exp_seg [8];
        logic [3:0] exp_an;
        exp_seg = '{7'b0111111, 7'b1101101, 7'b0000000, 7'b0000000,
                    7'b0111111, 7'b1101101, 7'b0111111, 7'b0111111};
        do_reset();
        lz_en = 1'b1;
        load  = 1'b1;
        value = 16'h0050;
        step();
        load  = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k == 4) lz_en = 1'b0;
            run_to(20 + 4 * k);
            exp_an = 4'b0001 << (k % 4);
            checks++;
            if (an !== exp_an || seg !== exp_seg[k]) begin
                errors++;
                $display("FAIL lz digit%0d lz_en=%b: an=%b seg=%b want %b %b", k % 4, lz_en, an, seg, exp_an, exp_seg[k]);
            end
        end
    endtask

    task automatic test_dp_blank();
        logic [6:0] exp_seg [4];
        logic       exp_dp  [4];
        logic [3:0] exp_an;
        exp_seg = '{7'b0000000, 7'b1111111, 7'b1111111, 7'b1111111};
        exp_dp  = '{1'b0, 1'b0, 1'b1, 1'b0};
        do_reset();
        load     = 1'b1;
        value    = 16'h8888;
        dp_in    = 4'b0101;
        blank_in = 4'b0001;
        step();
        dp_in    = 4'b0100;
        step();
        load     = 1'b0;
        dp_in    = 4'b0000;
        blank_in = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            run_to(20 + 4 * k);
            exp_an = 4'b0001 << k;
            checks++;
            if (an !== exp_an || seg !== exp_seg[k] || dp !== exp_dp[k]) begin
                errors++;
                $display("FAIL dp_blank digit%0d: an=%b seg=%b dp=%b want %b %b %b", k, an, seg, dp, exp_an, exp_seg[k], exp_dp[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        run_to(5);
        load  = 1'b1;
        value = 16'h2222;
        step();
        load  = 1'b0;
        run_to(15);
        load  = 1'b1;
        value = 16'h0007;
        step();
        load  = 1'b0;
        value = 16'h0000;
        checks++;
        if (frame_done !== 1'b1 || an !== 4'b1000) begin
            errors++;
            $display("FAIL wrap_load_edge: fd=%b an=%b want 1 1000", frame_done, an);
        end
        run_to(20);
        checks++;
        if (an !== 4'b0001 || seg !== 7'b0000111) begin
            errors++;
            $display("FAIL wrap_load_digit0: an=%b seg=%b want 0001 0000111", an, seg);
        end
        run_to(24);
        checks++;
        if (an !== 4'b0010 || seg !== 7'b0111111) begin
            errors++;
            $display("FAIL wrap_load_digit1: an=%b seg=%b want 0010 0111111", an, seg);
        end
        load  = 1'b1;
        value = 16'h9999;
        step();
        load  = 1'b0;
        run_to(26);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (an !== 4'b0000 || seg !== 7'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL midframe_reset: an=%b seg=%b fd=%b want 0000 0000000 0", an, seg, frame_done);
        end
        do_reset();
        run_to(4);
        checks++;
        if (an !== 4'b0001 || seg !== 7'b0111111) begin
            errors++;
            $display("FAIL post_reset_digit0: an=%b seg=%b want 0001 0111111", an, seg);
        end
        run_to(20);
        checks++;
        if (an !== 4'b0001 || seg !== 7'b0111111) begin
            errors++;
            $display("FAIL staged_discarded: an=%b seg=%b want 0001 0111111", an, seg);
        end
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        cyc      = 0;
        rst_n    = 1'b0;
        load     = 1'b0;
        value    = '0;
        dp_in    = '0;
        blank_in = '0;
        lz_en    = 1'b0;
        test_reset();
        test_scan();
        test_load_midframe();
        test_lz();
        test_dp_blank();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
